prco_lmem_dp: RTL and testbench

Parametrised dual-port local memory for the prco core, the successor to the single-port local memory. Port A is a synchronous read/write port with byte enables and a selectable write mode. Port B is an independent read-only port for the fetch/debug path. An internal clear sequencer zeroes the whole array after every reset and holds the block not-ready until the array is clean.

---
 rtl/prco_lmem_dp_if.sv | 25 ++
 rtl/prco_lmem_dp.sv | 99 +++++++++
 tb/tb_prco_lmem_dp.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/prco_lmem_dp_if.sv
// Port A / port B bus of the prco dual-port local memory.
// Signal names match the memory's pin names so both sides read the same.
interface prco_lmem_dp_if #(
  parameter int WIDTH = 16
);
  logic                 i_mem_we;
  logic [WIDTH/8-1:0]   i_mem_be;
  logic [15:0]          i_mem_addr;
  logic [WIDTH-1:0]     i_mem_dina;
  logic [WIDTH-1:0]     q_mem_douta;
  logic [15:0]          i_mem_addrb;
  logic [WIDTH-1:0]     q_mem_doutb;
  logic                 q_ready;
  logic                 q_err;

  modport master (
    output i_mem_we, i_mem_be, i_mem_addr, i_mem_dina, i_mem_addrb,
    input  q_mem_douta, q_mem_doutb, q_ready, q_err
  );

  modport slave (
    input  i_mem_we, i_mem_be, i_mem_addr, i_mem_dina, i_mem_addrb,
    output q_mem_douta, q_mem_doutb, q_ready, q_err
  );
endinterface

// File: rtl/prco_lmem_dp.sv
// Dual-port local memory: port A read/write with byte enables, port B read-only.
// A clear sequencer zeroes every word after reset before accesses are accepted.
module prco_lmem_dp #(
  parameter int DEPTH       = 32,
  parameter int WIDTH       = 16,
  parameter int WRITE_FIRST = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  prco_lmem_dp_if.slave  bus
);
  localparam int NB = WIDTH / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_ptr, w_ptr_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_douta, r_doutb;
  logic             r_err;

  logic             w_a_ok, w_b_ok;
  logic [AW-1:0]    w_idx_a, w_idx_b;
  logic [WIDTH-1:0] w_old_a, w_old_b, w_merged;
  logic             w_we;
  logic [AW-1:0]    w_widx;
  logic [WIDTH-1:0] w_wdat;

  // Full 16-bit compare: out-of-range addresses must never alias onto low words.
  assign w_a_ok  = (32'(bus.i_mem_addr)  < 32'(DEPTH));
  assign w_b_ok  = (32'(bus.i_mem_addrb) < 32'(DEPTH));
  assign w_idx_a = bus.i_mem_addr[AW-1:0];
  assign w_idx_b = bus.i_mem_addrb[AW-1:0];
  assign w_old_a = w_a_ok ? r_mem[w_idx_a] : '0;
  assign w_old_b = w_b_ok ? r_mem[w_idx_b] : '0;

  always_comb begin
    w_merged = w_old_a;
    for (int n = 0; n < NB; n++)
      if (bus.i_mem_be[n]) w_merged[8*n +: 8] = bus.i_mem_dina[8*n +: 8];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = 1'b0;
    w_widx      = w_idx_a;
    w_wdat      = w_merged;
    case (r_state)
      CLEAR: begin
        w_we   = 1'b1;
        w_widx = r_ptr;
        w_wdat = '0;
        if (r_ptr == AW'(DEPTH - 1)) w_state_nxt = READY;
        else                         w_ptr_nxt   = r_ptr + AW'(1);
      end
      READY: w_we = bus.i_mem_we && w_a_ok && (|bus.i_mem_be);
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Array has no reset; the clear sequence is what makes it clean.
  always_ff @(posedge i_clk) begin
    if (w_we && !i_rst) r_mem[w_widx] <= w_wdat;
  end

  // Port B reads the pre-edge word, so a same-cycle port A write is not visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_douta <= '0;
      r_doutb <= '0;
      r_err   <= 1'b0;
    end else if (r_state != READY) begin
      r_douta <= '0;
      r_doutb <= '0;
      r_err   <= 1'b0;
    end else begin
      r_douta <= !w_a_ok ? '0 : (WRITE_FIRST != 0) ? w_merged : w_old_a;
      r_doutb <= w_old_b;
      r_err   <= !w_a_ok || !w_b_ok;
    end
  end

  assign bus.q_mem_douta = r_douta;
  assign bus.q_mem_doutb = r_doutb;
  assign bus.q_err       = r_err;
  assign bus.q_ready     = (r_state == READY);
endmodule

// File: tb/tb_prco_lmem_dp.sv
// Directed bench: write-first, read-first and DEPTH=24 instances share clock/reset.
module tb_prco_lmem_dp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  prco_lmem_dp_if #(.WIDTH(16)) bw ();
  prco_lmem_dp_if #(.WIDTH(16)) br ();
  prco_lmem_dp_if #(.WIDTH(16)) bo ();

  prco_lmem_dp #(.DEPTH(32), .WIDTH(16), .WRITE_FIRST(1)) u_wf (.i_clk(clk), .i_rst(rst), .bus(bw));
  prco_lmem_dp #(.DEPTH(32), .WIDTH(16), .WRITE_FIRST(0)) u_rf (.i_clk(clk), .i_rst(rst), .bus(br));
  prco_lmem_dp #(.DEPTH(24), .WIDTH(16), .WRITE_FIRST(1)) u_oo (.i_clk(clk), .i_rst(rst), .bus(bo));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bw.i_mem_we = 0; bw.i_mem_be = 0; bw.i_mem_addr = 0; bw.i_mem_dina = 0; bw.i_mem_addrb = 0;
    br.i_mem_we = 0; br.i_mem_be = 0; br.i_mem_addr = 0; br.i_mem_dina = 0; br.i_mem_addrb = 0;
    bo.i_mem_we = 0; bo.i_mem_be = 0; bo.i_mem_addr = 0; bo.i_mem_dina = 0; bo.i_mem_addrb = 0;
  endtask

  task automatic reset_and_clear();
    rst = 1'b1;
    step();
    chk("rst_ready", 32'(bw.q_ready), 0);
    chk("rst_err",   32'(bw.q_err), 0);
    chk("rst_douta", 32'(bw.q_mem_douta), 0);
    chk("rst_doutb", 32'(bw.q_mem_doutb), 0);
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk("clr_ready32", 32'(bw.q_ready), 32'(i == 32));
      chk("clr_ready24", 32'(bo.q_ready), 32'(i >= 24));
    end
  endtask

  initial begin
    idle();
    #2;
    reset_and_clear();

    // Pre-load nonzero data, then confirm a fresh clear wipes it
    for (int a = 0; a < 32; a++) begin
      bw.i_mem_we = 1; bw.i_mem_be = 2'b11; bw.i_mem_addr = 16'(a); bw.i_mem_dina = 16'h1000 + 16'(a);
      step();
    end
    idle();
    bw.i_mem_addrb = 16'd7;
    step();
    chk("preload_b7", 32'(bw.q_mem_doutb), 32'h1007);
    reset_and_clear();
    for (int a = 0; a < 32; a++) begin
      bw.i_mem_addrb = 16'(a);
      step();
      chk("clean_b", 32'(bw.q_mem_doutb), 0);
    end
    idle();

    // Write-first vs read-first
    bw.i_mem_we = 1; bw.i_mem_be = 2'b11; bw.i_mem_addr = 0; bw.i_mem_dina = 16'h1111;
    br.i_mem_we = 1; br.i_mem_be = 2'b11; br.i_mem_addr = 0; br.i_mem_dina = 16'h1111;
    step();
    bw.i_mem_dina = 16'hab00;
    br.i_mem_dina = 16'hab00;
    step();
    chk("wf_douta", 32'(bw.q_mem_douta), 32'hab00);
    chk("rf_douta_old", 32'(br.q_mem_douta), 32'h1111);
    idle();
    step();
    chk("wf_reread", 32'(bw.q_mem_douta), 32'hab00);
    chk("rf_reread", 32'(br.q_mem_douta), 32'hab00);

    // Byte enables
    bw.i_mem_we = 1; bw.i_mem_be = 2'b11; bw.i_mem_addr = 1; bw.i_mem_dina = 16'h1234;
    step();
    bw.i_mem_be = 2'b01; bw.i_mem_dina = 16'hcdef;
    step();
    chk("be01", 32'(bw.q_mem_douta), 32'h12ef);
    bw.i_mem_be = 2'b10; bw.i_mem_dina = 16'hab00;
    step();
    chk("be10", 32'(bw.q_mem_douta), 32'habef);
    bw.i_mem_be = 2'b00; bw.i_mem_dina = 16'hffff;
    step();
    chk("be00_a", 32'(bw.q_mem_douta), 32'habef);
    idle();
    bw.i_mem_addrb = 1;
    step();
    chk("be00_b", 32'(bw.q_mem_doutb), 32'habef);

    // Collision on both modes: port B sees the old word
    bw.i_mem_we = 1; bw.i_mem_be = 2'b11; bw.i_mem_addr = 5; bw.i_mem_dina = 16'haaaa;
    br.i_mem_we = 1; br.i_mem_be = 2'b11; br.i_mem_addr = 5; br.i_mem_dina = 16'haaaa;
    step();
    bw.i_mem_dina = 16'h5555; bw.i_mem_addrb = 5;
    br.i_mem_dina = 16'h5555; br.i_mem_addrb = 5;
    step();
    chk("coll_wf_old", 32'(bw.q_mem_doutb), 32'haaaa);
    chk("coll_rf_old", 32'(br.q_mem_doutb), 32'haaaa);
    bw.i_mem_we = 0; br.i_mem_we = 0;
    step();
    chk("coll_wf_new", 32'(bw.q_mem_doutb), 32'h5555);
    chk("coll_rf_new", 32'(br.q_mem_doutb), 32'h5555);
    idle();

    // Out of range on the DEPTH=24 instance
    for (int a = 0; a < 24; a++) begin
      bo.i_mem_we = 1; bo.i_mem_be = 2'b11; bo.i_mem_addr = 16'(a); bo.i_mem_dina = 16'h2000 + 16'(a);
      step();
    end
    chk("oor_err_idle", 32'(bo.q_err), 0);
    bo.i_mem_addr = 16'd24; bo.i_mem_dina = 16'hffff;
    step();
    chk("oor_w_err", 32'(bo.q_err), 1);
    chk("oor_w_douta", 32'(bo.q_mem_douta), 0);
    idle();
    step();
    chk("oor_w_errdrop", 32'(bo.q_err), 0);
    for (int a = 0; a < 24; a++) begin
      bo.i_mem_addrb = 16'(a);
      step();
      chk("oor_intact", 32'(bo.q_mem_doutb), 32'h2000 + 32'(a));
    end
    bo.i_mem_addrb = 16'd40;
    step();
    chk("oor_b_err", 32'(bo.q_err), 1);
    chk("oor_b_doutb", 32'(bo.q_mem_doutb), 0);
    bo.i_mem_addrb = 16'd23;
    step();
    chk("oor_b_errdrop", 32'(bo.q_err), 0);
    bo.i_mem_addr = 16'd30; bo.i_mem_addrb = 16'd50;
    step();
    chk("oor_both_err", 32'(bo.q_err), 1);
    idle();
    step();
    chk("oor_both_drop", 32'(bo.q_err), 0);

    // Reset mid-clear; accesses during the clear are ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_ready", 32'(bw.q_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      bw.i_mem_we = 1; bw.i_mem_be = 2'b11; bw.i_mem_addr = 16'((i + 30) % 32);
      bw.i_mem_dina = 16'hffff; bw.i_mem_addrb = 16'd40;
      step();
      chk("mc_ready", 32'(bw.q_ready), 32'(i == 32));
      chk("mc_err", 32'(bw.q_err), 0);
      chk("mc_douta", 32'(bw.q_mem_douta), 0);
      chk("mc_doutb", 32'(bw.q_mem_doutb), 0);
      if (i == 32) idle();
    end
    for (int a = 0; a < 32; a++) begin
      bw.i_mem_addrb = 16'(a);
      step();
      chk("mc_clean", 32'(bw.q_mem_doutb), 0);
    end
    chk("mc_err_end", 32'(bw.q_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
